// File: rtl/fixed_dot_product_arb_pkg.sv
// Shared types and helpers for the dot-product arbiter: FSM encoding and the
// round-robin picker used to select the next requester.
package fixed_dot_product_arb_pkg;

    localparam int unsigned RR_MAX_REQ = 64;
    localparam int unsigned RR_IDX_W   = 6;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    // First set bit of req at or after ptr, wrapping modulo num; ptr if none set.
    function automatic int unsigned rr_pick(
        input logic [RR_MAX_REQ-1:0] req,
        input int unsigned           ptr,
        input int unsigned           num
    );
        int unsigned idx;
        logic        found;
        rr_pick = ptr;
        found   = 1'b0;
        for (int unsigned i = 0; i < RR_MAX_REQ; i++) begin
            idx = (ptr + i) % num;
            if (!found && (i < num) && req[idx[RR_IDX_W-1:0]]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/fixed_dot_product_tag_fifo.sv
// Register FIFO holding the requester tag of every issued-but-unreturned product.
module fixed_dot_product_tag_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Pointers wrap explicitly so a depth of one still behaves.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
            end
            if (push_ok && !pop_ok) begin
                count <= count + CNT_W'(1);
            end else if (pop_ok && !push_ok) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/fixed_dot_product_arbiter.sv
// Round-robin arbiter sharing one dot-product unit between NUM_REQ requesters,
// with a tag FIFO routing scalar results back in issue order.
module fixed_dot_product_arbiter
    import fixed_dot_product_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned IN_WIDTH     = 32,
    parameter int unsigned WEIGHT_WIDTH = 16,
    parameter int unsigned IN_SIZE      = 4,
    parameter int unsigned OUT_WIDTH    = IN_WIDTH + WEIGHT_WIDTH + $clog2(IN_SIZE),
    parameter int unsigned MAX_INFLIGHT = 4
) (
    input  logic                                             clk,
    input  logic                                             rst,
    input  logic [NUM_REQ-1:0][IN_SIZE-1:0][IN_WIDTH-1:0]     req_data,
    input  logic [NUM_REQ-1:0][IN_SIZE-1:0][WEIGHT_WIDTH-1:0] req_weight,
    input  logic [NUM_REQ-1:0]                               req_valid,
    output logic [NUM_REQ-1:0]                               req_ready,
    output logic [IN_SIZE-1:0][IN_WIDTH-1:0]                 dp_data_in,
    output logic                                             dp_data_in_valid,
    input  logic                                             dp_data_in_ready,
    output logic [IN_SIZE-1:0][WEIGHT_WIDTH-1:0]             dp_weight,
    output logic                                             dp_weight_valid,
    input  logic                                             dp_weight_ready,
    input  logic [OUT_WIDTH-1:0]                             dp_data_out,
    input  logic                                             dp_data_out_valid,
    output logic                                             dp_data_out_ready,
    output logic [OUT_WIDTH-1:0]                             resp_data,
    output logic [NUM_REQ-1:0]                               resp_valid,
    input  logic [NUM_REQ-1:0]                               resp_ready
);

    localparam int unsigned TAG_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_t           state;
    state_t           state_nxt;
    logic [TAG_W-1:0] grant;
    logic [TAG_W-1:0] grant_nxt;
    logic [TAG_W-1:0] rr_ptr;
    logic [TAG_W-1:0] rr_ptr_nxt;
    logic             data_sent;
    logic             data_sent_nxt;
    logic             weight_sent;
    logic             weight_sent_nxt;
    logic             data_hs;
    logic             weight_hs;
    logic             beat_done;

    logic [TAG_W-1:0] head;
    logic             fifo_full;
    logic             fifo_empty;
    logic             resp_hs;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            grant       <= '0;
            rr_ptr      <= '0;
            data_sent   <= 1'b0;
            weight_sent <= 1'b0;
        end else begin
            state       <= state_nxt;
            grant       <= grant_nxt;
            rr_ptr      <= rr_ptr_nxt;
            data_sent   <= data_sent_nxt;
            weight_sent <= weight_sent_nxt;
        end
    end

    // Channels complete independently; the beat retires once both have handshaken.
    always_comb begin
        state_nxt        = state;
        grant_nxt        = grant;
        rr_ptr_nxt       = rr_ptr;
        data_sent_nxt    = data_sent;
        weight_sent_nxt  = weight_sent;
        dp_data_in_valid = 1'b0;
        dp_weight_valid  = 1'b0;
        req_ready        = '0;
        data_hs          = 1'b0;
        weight_hs        = 1'b0;
        beat_done        = 1'b0;

        case (state)
            IDLE: begin
                if ((|req_valid) && !fifo_full) begin
                    grant_nxt       = TAG_W'(rr_pick(RR_MAX_REQ'(req_valid), 32'(rr_ptr), NUM_REQ));
                    data_sent_nxt   = 1'b0;
                    weight_sent_nxt = 1'b0;
                    state_nxt       = ISSUE;
                end
            end
            ISSUE: begin
                dp_data_in_valid = !data_sent;
                dp_weight_valid  = !weight_sent;
                data_hs          = dp_data_in_valid && dp_data_in_ready;
                weight_hs        = dp_weight_valid && dp_weight_ready;
                if (data_hs) begin
                    data_sent_nxt = 1'b1;
                end
                if (weight_hs) begin
                    weight_sent_nxt = 1'b1;
                end
                beat_done = (data_sent || data_hs) && (weight_sent || weight_hs);
                if (beat_done) begin
                    req_ready  = NUM_REQ'(1) << grant;
                    rr_ptr_nxt = (grant == TAG_W'(NUM_REQ - 1)) ? '0 : grant + TAG_W'(1);
                    state_nxt  = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign dp_data_in = req_data[grant];
    assign dp_weight  = req_weight[grant];

    // Return path is purely combinational: the FIFO head names the result owner.
    assign resp_data         = dp_data_out;
    assign dp_data_out_ready = resp_ready[head] && !fifo_empty;
    assign resp_valid        = (dp_data_out_valid && !fifo_empty) ? (NUM_REQ'(1) << head) : '0;
    assign resp_hs           = dp_data_out_valid && dp_data_out_ready;

    fixed_dot_product_tag_fifo #(
        .DEPTH (MAX_INFLIGHT),
        .WIDTH (TAG_W)
    ) u_tag_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (beat_done),
        .push_data (grant),
        .pop       (resp_hs),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_fixed_dot_product_arbiter.sv
// Directed bench for fixed_dot_product_arbiter; the bench plays the shared unit
// by driving channel readies and results directly.
module tb_fixed_dot_product_arbiter;

    localparam int unsigned NUM_REQ      = 4;
    localparam int unsigned IN_WIDTH     = 32;
    localparam int unsigned WEIGHT_WIDTH = 16;
    localparam int unsigned IN_SIZE      = 4;
    localparam int unsigned OUT_WIDTH    = IN_WIDTH + WEIGHT_WIDTH + $clog2(IN_SIZE);
    localparam int unsigned MAX_INFLIGHT = 4;

    logic                                             clk;
    logic                                             rst;
    logic [NUM_REQ-1:0][IN_SIZE-1:0][IN_WIDTH-1:0]     req_data;
    logic [NUM_REQ-1:0][IN_SIZE-1:0][WEIGHT_WIDTH-1:0] req_weight;
    logic [NUM_REQ-1:0]                               req_valid;
    logic [NUM_REQ-1:0]                               req_ready;
    logic [IN_SIZE-1:0][IN_WIDTH-1:0]                 dp_data_in;
    logic                                             dp_data_in_valid;
    logic                                             dp_data_in_ready;
    logic [IN_SIZE-1:0][WEIGHT_WIDTH-1:0]             dp_weight;
    logic                                             dp_weight_valid;
    logic                                             dp_weight_ready;
    logic [OUT_WIDTH-1:0]                             dp_data_out;
    logic                                             dp_data_out_valid;
    logic                                             dp_data_out_ready;
    logic [OUT_WIDTH-1:0]                             resp_data;
    logic [NUM_REQ-1:0]                               resp_valid;
    logic [NUM_REQ-1:0]                               resp_ready;

    int checks = 0;
    int passes = 0;

    fixed_dot_product_arbiter #(
        .NUM_REQ      (NUM_REQ),
        .IN_WIDTH     (IN_WIDTH),
        .WEIGHT_WIDTH (WEIGHT_WIDTH),
        .IN_SIZE      (IN_SIZE),
        .OUT_WIDTH    (OUT_WIDTH),
        .MAX_INFLIGHT (MAX_INFLIGHT)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .req_data          (req_data),
        .req_weight        (req_weight),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .dp_data_in        (dp_data_in),
        .dp_data_in_valid  (dp_data_in_valid),
        .dp_data_in_ready  (dp_data_in_ready),
        .dp_weight         (dp_weight),
        .dp_weight_valid   (dp_weight_valid),
        .dp_weight_ready   (dp_weight_ready),
        .dp_data_out       (dp_data_out),
        .dp_data_out_valid (dp_data_out_valid),
        .dp_data_out_ready (dp_data_out_ready),
        .resp_data         (resp_data),
        .resp_valid        (resp_valid),
        .resp_ready        (resp_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Advance past the next rising edge; inputs are then changed mid-cycle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst               = 1'b1;
        req_data          = '0;
        req_weight        = '0;
        req_valid         = '0;
        dp_data_in_ready  = 1'b0;
        dp_weight_ready   = 1'b0;
        dp_data_out       = '0;
        dp_data_out_valid = 1'b0;
        resp_ready        = '0;
        for (int r = 0; r < NUM_REQ; r++) begin
            for (int k = 0; k < IN_SIZE; k++) begin
                req_data[r][k]   = IN_WIDTH'(16 * r + k + 1);
                req_weight[r][k] = WEIGHT_WIDTH'(1);
            end
        end
        #1;
        chk("rst_req_ready", 64'(req_ready), 64'(0));
        chk("rst_dv", 64'(dp_data_in_valid), 64'(0));
        chk("rst_wv", 64'(dp_weight_valid), 64'(0));
        chk("rst_out_ready", 64'(dp_data_out_ready), 64'(0));
        chk("rst_resp_valid", 64'(resp_valid), 64'(0));
        tick();
        tick();
        rst = 1'b0;

        // 1: single requester 2, data {1,2,3,4}, unit weights -> result 10
        for (int k = 0; k < IN_SIZE; k++) req_data[2][k] = IN_WIDTH'(k + 1);
        req_valid        = 4'b0100;
        dp_data_in_ready = 1'b1;
        dp_weight_ready  = 1'b1;
        resp_ready       = 4'b1111;
        #1;
        chk("t1_idle_dv", 64'(dp_data_in_valid), 64'(0));
        chk("t1_idle_req_ready", 64'(req_ready), 64'(0));
        tick();
        chk("t1_dv", 64'(dp_data_in_valid), 64'(1));
        chk("t1_wv", 64'(dp_weight_valid), 64'(1));
        chk("t1_req_ready", 64'(req_ready), 64'(4'b0100));
        chk("t1_data0", 64'(dp_data_in[0]), 64'(1));
        chk("t1_data3", 64'(dp_data_in[3]), 64'(4));
        chk("t1_weight2", 64'(dp_weight[2]), 64'(1));
        tick();
        req_valid         = '0;
        dp_data_out       = OUT_WIDTH'(10);
        dp_data_out_valid = 1'b1;
        #1;
        chk("t1_req_ready_off", 64'(req_ready), 64'(0));
        chk("t1_resp_valid", 64'(resp_valid), 64'(4'b0100));
        chk("t1_resp_data", 64'(resp_data), 64'(10));
        chk("t1_out_ready", 64'(dp_data_out_ready), 64'(1));
        tick();
        chk("t1_empty_resp_valid", 64'(resp_valid), 64'(0));
        chk("t1_empty_out_ready", 64'(dp_data_out_ready), 64'(0));
        dp_data_out_valid = 1'b0;

        // 2: all requesting from a fresh reset -> grants 0,1,2,3,0, results in order
        rst = 1'b1;
        tick();
        rst               = 1'b0;
        req_valid         = 4'b1111;
        dp_data_out_valid = 1'b1;
        dp_data_out       = OUT_WIDTH'(77);
        for (int g = 0; g < 5; g++) begin
            #1;
            chk("t2_idle_resp_valid", 64'(resp_valid),
                (g == 0) ? 64'(0) : 64'(1) << ((g - 1) % 4));
            chk("t2_idle_req_ready", 64'(req_ready), 64'(0));
            tick();
            chk("t2_grant", 64'(req_ready), 64'(1) << (g % 4));
            chk("t2_issue_resp_valid", 64'(resp_valid), 64'(0));
            tick();
        end
        req_valid = '0;
        #1;
        chk("t2_last_resp_valid", 64'(resp_valid), 64'(4'b0001));
        tick();
        chk("t2_drained", 64'(resp_valid), 64'(0));
        dp_data_out_valid = 1'b0;

        // 3: split handshake, weight channel stalls three cycles
        req_valid        = 4'b0001;
        dp_data_in_ready = 1'b1;
        dp_weight_ready  = 1'b0;
        tick();
        chk("t3_c1_dv", 64'(dp_data_in_valid), 64'(1));
        chk("t3_c1_wv", 64'(dp_weight_valid), 64'(1));
        chk("t3_c1_req_ready", 64'(req_ready), 64'(0));
        for (int c = 0; c < 2; c++) begin
            tick();
            chk("t3_held_dv", 64'(dp_data_in_valid), 64'(0));
            chk("t3_held_wv", 64'(dp_weight_valid), 64'(1));
            chk("t3_held_req_ready", 64'(req_ready), 64'(0));
        end
        tick();
        dp_weight_ready = 1'b1;
        #1;
        chk("t3_done_req_ready", 64'(req_ready), 64'(4'b0001));
        chk("t3_done_dv", 64'(dp_data_in_valid), 64'(0));
        tick();
        req_valid         = '0;
        dp_data_out_valid = 1'b1;
        #1;
        chk("t3_resp_valid", 64'(resp_valid), 64'(4'b0001));
        tick();
        chk("t3_single_push", 64'(resp_valid), 64'(0));
        dp_data_out_valid = 1'b0;

        // 4: results withheld, FIFO fills after four beats (order 1,2,3,0)
        req_valid = 4'b1111;
        for (int b = 0; b < 4; b++) begin
            tick();
            chk("t4_fill_grant", 64'(req_ready), 64'(1) << ((b + 1) % 4));
            tick();
        end
        for (int c = 0; c < 2; c++) begin
            #1;
            chk("t4_full_dv", 64'(dp_data_in_valid), 64'(0));
            chk("t4_full_req_ready", 64'(req_ready), 64'(0));
            tick();
        end
        dp_data_out_valid = 1'b1;
        #1;
        chk("t4_pop_owner", 64'(resp_valid), 64'(4'b0010));
        chk("t4_pop_cycle_dv", 64'(dp_data_in_valid), 64'(0));
        tick();
        dp_data_out_valid = 1'b0;
        #1;
        chk("t4_after_pop_dv", 64'(dp_data_in_valid), 64'(0));
        tick();
        chk("t4_resume_dv", 64'(dp_data_in_valid), 64'(1));
        chk("t4_resume_grant", 64'(req_ready), 64'(4'b0010));
        tick();
        req_valid = '0;

        // 5: head owner (2) not ready -> result held until it is
        dp_data_out_valid = 1'b1;
        resp_ready        = 4'b0000;
        #1;
        chk("t5_resp_valid", 64'(resp_valid), 64'(4'b0100));
        chk("t5_out_ready_low", 64'(dp_data_out_ready), 64'(0));
        tick();
        chk("t5_held", 64'(resp_valid), 64'(4'b0100));
        resp_ready = 4'b0100;
        #1;
        chk("t5_out_ready_high", 64'(dp_data_out_ready), 64'(1));
        tick();
        chk("t5_next_owner", 64'(resp_valid), 64'(4'b1000));
        chk("t5_next_not_ready", 64'(dp_data_out_ready), 64'(0));
        resp_ready = 4'b1111;
        tick();
        tick();
        tick();
        chk("t5_drained", 64'(resp_valid), 64'(0));
        dp_data_out_valid = 1'b0;

        // 6: reset mid-beat with only the data channel sent
        req_valid        = 4'b0100;
        dp_data_in_ready = 1'b1;
        dp_weight_ready  = 1'b0;
        tick();
        tick();
        chk("t6_data_sent", 64'(dp_data_in_valid), 64'(0));
        chk("t6_wv_pending", 64'(dp_weight_valid), 64'(1));
        rst = 1'b1;
        #1;
        chk("t6_rst_wv", 64'(dp_weight_valid), 64'(0));
        chk("t6_rst_dv", 64'(dp_data_in_valid), 64'(0));
        chk("t6_rst_req_ready", 64'(req_ready), 64'(0));
        tick();
        rst             = 1'b0;
        req_valid       = 4'b1111;
        dp_weight_ready = 1'b1;
        tick();
        chk("t6_first_grant", 64'(req_ready), 64'(4'b0001));
        req_valid = '0;
        tick();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/fixed_dot_product_arbiter.md
# fixed_dot_product_arbiter

- Shares one `fixed_dot_product` instance between `NUM_REQ` requesters.
- Each requester offers a (data, weight) vector pair. The arbiter grants round-robin and drives the pair into the shared unit's two input channels.
- A tag FIFO records which requester each product belongs to, so scalar results are routed back in issue order.
- The block sits between the per-head/per-row producers and the single dot-product datapath.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters (≥2).
- `IN_WIDTH`, 32: activation element width.
- `WEIGHT_WIDTH`, 16: weight element width.
- `IN_SIZE`, 4: elements per vector.
- `OUT_WIDTH`, `IN_WIDTH+WEIGHT_WIDTH+$clog2(IN_SIZE)`: result width.
- `MAX_INFLIGHT`, 4: tag FIFO depth, i.e. the maximum number of issued-but-unreturned products (power of two).

Ports:
- `clk` in 1: clock. One clock domain.
- `rst` in 1: reset, asynchronous and active-high.
- `req_data` in `[NUM_REQ][IN_SIZE][IN_WIDTH]`: activation vectors.
- `req_weight` in `[NUM_REQ][IN_SIZE][WEIGHT_WIDTH]`: weight vectors.
- `req_valid` in `NUM_REQ`: per-requester valid; the pair is treated as one beat.
- `req_ready` out `NUM_REQ`: one-hot, pulses when the beat is fully issued.
- `dp_data_in` out `[IN_SIZE][IN_WIDTH]`, `dp_data_in_valid` out 1, `dp_data_in_ready` in 1: activation channel to the shared unit.
- `dp_weight` out `[IN_SIZE][WEIGHT_WIDTH]`, `dp_weight_valid` out 1, `dp_weight_ready` in 1: weight channel to the shared unit.
- `dp_data_out` in `OUT_WIDTH`, `dp_data_out_valid` in 1, `dp_data_out_ready` out 1: result from the shared unit.
- `resp_data` out `OUT_WIDTH`: result, broadcast to all requesters.
- `resp_valid` out `NUM_REQ`: one-hot, the owner of the current result.
- `resp_ready` in `NUM_REQ`: per-requester ready.

## Operation
**FSM states:** IDLE, ISSUE.

**IDLE**
- Condition to leave: any `req_valid` is high and the tag FIFO is not full.
- Register `grant` = first requester with valid set, searching from `rr_ptr` upward with wrap.
- Clear `data_sent` and `weight_sent`, then go to ISSUE.

**ISSUE**
- `dp_data_in`/`dp_weight` are muxed from `grant`.
- `dp_data_in_valid = !data_sent`; `dp_weight_valid = !weight_sent`.
- Each channel's flag sets on its own handshake. The channels may complete in different cycles, which avoids deadlock with a joining downstream.

**Completion**
- Occurs in the cycle when the last outstanding channel handshakes.
- `req_ready[grant]=1` for exactly that cycle.
- Push `grant` into the tag FIFO.
- `rr_ptr <= grant+1` (mod `NUM_REQ`).
- Return to IDLE.
- The grant never changes mid-beat. The requester must hold valid and data until `req_ready`.

**Return path**
- `resp_data = dp_data_out`.
- `resp_valid[head] = dp_data_out_valid & !empty`.
- `dp_data_out_ready = resp_ready[head] & !empty`.
- A handshake pops the FIFO.
- When the FIFO is empty, `dp_data_out_ready=0` and `resp_valid=0`.

**Boundary conditions**
- Full FIFO: IDLE does not grant, even if a pop occurs in the same cycle. Issue resumes the cycle after the pop.
- Push and pop in the same cycle while not full: both take effect and occupancy is unchanged.
- Requester deasserting valid mid-beat: protocol violation, behaviour undefined.

**Arithmetic:** no arithmetic on data; pure muxing. `TAG_W = $clog2(NUM_REQ)`, pointer wrap is mod `MAX_INFLIGHT`.

## Timing
**Reset values**
- State IDLE, `rr_ptr=0`, FIFO empty, `data_sent=weight_sent=0`.
- Outputs: `req_ready=0`, `dp_data_in_valid=0`, `dp_weight_valid=0`, `dp_data_out_ready=0`, `resp_valid=0`.
- `dp_data_in`, `dp_weight` and `resp_data` are don't-care.
- Reset mid-beat abandons the beat and the FIFO contents. The environment must also reset the shared unit.

**Latency and throughput**
- `req_valid` rising in IDLE with a non-full FIFO: dp valids go high the next cycle.
- With both readies high, `req_ready` pulses in that same cycle.
- Minimum of 2 cycles per issued beat; the peak issue rate is one beat per 2 cycles.
- Return path is combinational: zero added latency, no output register.

## Structure
- Package `fixed_dot_product_arb_pkg`:
  - state enum `{IDLE, ISSUE}`
  - helper function `rr_pick(req, ptr)`, returning the index of the first set bit at or after `ptr`
- Sub-module `fixed_dot_product_tag_fifo`: `MAX_INFLIGHT` × `TAG_W` register FIFO with `full`/`empty`, push, and pop.
- The shared `fixed_dot_product` is instantiated outside this block, not inside it.

## Test plan
1. Single requester: `req_valid=4'b0100`, data {1,2,3,4}, weight {1,1,1,1}, dp readies high → `req_ready[2]` pulses on cycle 2; `resp_valid=4'b0100` with result 10; FIFO empty afterwards.
2. All four requesting continuously → grant order 0,1,2,3,0; one `req_ready` pulse every 2 cycles; results return to requesters in the same order.
3. Split handshake: `dp_weight_ready` low for 3 cycles while `dp_data_in_ready` is high → `dp_data_in_valid` drops after 1 cycle; `dp_weight_valid` is held; `req_ready` pulses only when the weight handshakes; exactly one FIFO push.
4. Backpressure: `dp_data_out_valid` forced low, 4 beats issued (`MAX_INFLIGHT=4`) → no 5th grant while FIFO full; one result popped → grant on the next cycle.
5. `resp_ready[head]=0` while `dp_data_out_valid=1` → `dp_data_out_ready=0` and the result is held; ready raised → pop.
6. Assert `rst` during ISSUE with `data_sent=1` → all valids/readies 0 immediately; after release, requester 0 wins first.
